// File: rtl/csr_if.sv
// CSR bus between the pipeline (master) and a CSR unit (slave).
//   read   : the instruction reads the addressed CSR this cycle
//   modify : 0 none, 1 write, 2 set bits, 3 clear bits, 4-7 none
//   wdata  : write/set/clear operand
//   addr   : 12-bit CSR address
//   rdata  : registered read data, zero when valid=0
//   valid  : registered; the address of the previous cycle hit an implemented CSR
interface csr_if;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, modify, wdata, addr, input  rdata, valid);
  modport slave  (input  read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_peripherals.sv
// CSR peripheral cluster: ID / clock-rate constants, 64-bit cycle and
// instret counters, and a byte-wide 8N1 UART.
// rdata/valid are zero when nothing matches, so the outputs can be OR-merged
// with other CSR units.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : CSR bus (slave side), response one cycle after the request
//   retired  : one instruction retired this cycle
//   rx       : UART serial input, asynchronous, idle high
//   tx       : UART serial output, idle high
module csr_peripherals #(
  parameter int          CLOCK_RATE = 12_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter logic [11:0] ID_BASE    = 12'hFC0,
  parameter logic [11:0] UART_ADDR  = 12'hBC0
) (
  input  logic  clk,
  input  logic  rst,
  csr_if.slave  bus,
  input  logic  retired,
  input  logic  rx,
  output logic  tx
);

  localparam int          DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int          HALF = DIV / 2;
  localparam int          CW   = $clog2(DIV + 1);
  localparam logic [31:0] KHZ  = 32'(CLOCK_RATE / 1000);

  function automatic logic [31:0] new_val(input logic [2:0] m, input logic [31:0] old,
                                          input logic [31:0] w);
    case (m)
      3'd1:    return w;
      3'd2:    return old | w;
      3'd3:    return old & ~w;
      default: return old;
    endcase
  endfunction

  logic do_mod, req;
  assign do_mod = bus.modify inside {3'd1, 3'd2, 3'd3};
  assign req    = bus.read | do_mod;

  // ---------------- counters ----------------
  logic [63:0] cycle, instret, cycle_inc, instret_inc;
  logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

  assign cycle_inc   = cycle + 64'd1;
  assign instret_inc = instret + {63'd0, retired};
  assign wr_cyc_lo   = do_mod && (bus.addr == 12'hB00);
  assign wr_cyc_hi   = do_mod && (bus.addr == 12'hB80);
  assign wr_ins_lo   = do_mod && (bus.addr == 12'hB02);
  assign wr_ins_hi   = do_mod && (bus.addr == 12'hB82);

  // A modified half takes the new value instead of the increment; when the
  // low half is modified the high half holds, so no carry leaks across.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle   <= '0;
      instret <= '0;
    end else begin
      cycle[31:0]    <= wr_cyc_lo ? new_val(bus.modify, cycle[31:0], bus.wdata) : cycle_inc[31:0];
      cycle[63:32]   <= wr_cyc_hi ? new_val(bus.modify, cycle[63:32], bus.wdata) :
                        wr_cyc_lo ? cycle[63:32] : cycle_inc[63:32];
      instret[31:0]  <= wr_ins_lo ? new_val(bus.modify, instret[31:0], bus.wdata) : instret_inc[31:0];
      instret[63:32] <= wr_ins_hi ? new_val(bus.modify, instret[63:32], bus.wdata) :
                        wr_ins_lo ? instret[63:32] : instret_inc[63:32];
    end
  end

  // ---------------- UART state ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, tx_byte;
  logic          tx_busy, tx_go, tx_last;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_full, rx_s1, rx_s2, rx_prev, pop;

  logic [31:0]   uart_val;
  assign uart_val = {22'd0, tx_busy, rx_full, rx_byte};

  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_go   = do_mod && (bus.addr == UART_ADDR) && !tx_busy;
  assign tx_last = (tx_cnt == CW'(DIV - 1));
  assign pop     = bus.read && (bus.addr == UART_ADDR) && rx_full;

  // Low byte of the modify result; only this part is transmitted.
  always_comb begin
    tx_byte = rx_byte;
    case (bus.modify)
      3'd1:    tx_byte = bus.wdata[7:0];
      3'd2:    tx_byte = rx_byte | bus.wdata[7:0];
      3'd3:    tx_byte = rx_byte & ~bus.wdata[7:0];
      default: tx_byte = rx_byte;
    endcase
  end

  // ---------------- CSR read mux / response ----------------
  logic [31:0] rd;
  logic        hit;

  always_comb begin
    hit = 1'b1;
    rd  = '0;
    case (bus.addr)
      12'hF11, 12'hF12, 12'hF13, 12'hF14: rd = '0;
      12'hB00, 12'hC00, 12'hC01:          rd = cycle[31:0];
      12'hB80, 12'hC80, 12'hC81:          rd = cycle[63:32];
      12'hB02, 12'hC02:                   rd = instret[31:0];
      12'hB82, 12'hC82:                   rd = instret[63:32];
      default: begin
        if (bus.addr == ID_BASE)        rd = KHZ;
        else if (bus.addr == UART_ADDR) rd = uart_val;
        else                            hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.valid <= req && hit;
      bus.rdata <= (req && hit) ? rd : '0;
    end
  end

  // ---------------- transmitter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_go) begin
          tx_shift <= tx_byte;
          tx       <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_last) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx       <= tx_shift[0];
          tx_state <= TX_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_DATA: if (tx_last) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx       <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_shift <= tx_shift >> 1;
            tx       <= tx_shift[1];
            tx_bit   <= tx_bit + 1'b1;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        TX_STOP: if (tx_last) tx_state <= TX_IDLE;
                 else         tx_cnt   <= tx_cnt + 1'b1;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  // rx_s1/rx_s2 synchronise the line; rx_prev detects the start-bit edge.
  // A pop and a completed frame in the same cycle leave rx_full set because
  // the frame assignment comes later in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_full  <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (pop) rx_full <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_cnt == CW'(HALF - 1)) begin
          // line back high at mid start bit: a glitch, not a frame
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == CW'(DIV - 1)) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else                rx_bit   <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == CW'(DIV - 1)) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
          if (rx_s2) begin
            rx_byte <= rx_shift;
            rx_full <= 1'b1;
          end
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_peripherals.sv
module tb_csr_peripherals;
  localparam int DIV = 12_000_000 / 115200;

  logic clk, rst, retired, rx, tx;
  csr_if bus();

  csr_peripherals dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .retired (retired),
    .rx      (rx),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          fails = 0;
  logic [63:0] cyc_model;
  logic [9:0]  frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock; the bench's cycle counter tracks the DUT's free-running count
  task automatic tick();
    if (rst) cyc_model = 64'd0;
    else     cyc_model = cyc_model + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_req(input logic rd, input logic [2:0] m, input logic [31:0] wd,
                         input logic [11:0] a, input logic ev, input logic [31:0] ed,
                         input string tag);
    exp_t        e;
    logic [63:0] old;
    bus.read   = rd;
    bus.modify = m;
    bus.wdata  = wd;
    bus.addr   = a;
    sb.push_back('{tag: tag, v: ev, d: ed});
    old = cyc_model;
    tick();
    bus.read   = 1'b0;
    bus.modify = 3'd0;
    if (m == 3'd1 && a == 12'hB00) cyc_model = {old[63:32], wd};
    if (m == 3'd1 && a == 12'hB80) cyc_model = {wd, old[31:0] + 32'd1};
    e = sb.pop_front();
    check({e.tag, "_valid"}, {31'd0, bus.valid}, {31'd0, e.v});
    check({e.tag, "_rdata"}, bus.rdata, e.d);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = stop;
    repeat (DIV) tick();
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1; retired = 1'b0; rx = 1'b1;
    bus.read = 1'b0; bus.modify = 3'd0; bus.wdata = '0; bus.addr = '0;
    cyc_model = '0;
    repeat (3) tick();
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;

    // IDs and cycle counter
    repeat (9) tick();
    csr_req(1, 0, 0, 12'hC00, 1, cyc_model[31:0], "cycle_a");
    repeat (9) tick();
    csr_req(1, 0, 0, 12'hC00, 1, cyc_model[31:0], "cycle_b");
    csr_req(1, 0, 0, 12'hFC0, 1, 32'd12000, "khz");
    csr_req(1, 0, 0, 12'hF14, 1, 32'd0, "mhartid");
    csr_req(1, 0, 0, 12'hF11, 1, 32'd0, "mvendorid");

    // mcycle carry, instret set/clear
    csr_req(0, 1, 32'd0, 12'hB80, 1, cyc_model[63:32], "wr_mcycleh");
    csr_req(0, 1, 32'hFFFF_FFFF, 12'hB00, 1, cyc_model[31:0], "wr_mcycle");
    repeat (3) tick();
    csr_req(1, 0, 0, 12'hB80, 1, 32'd1, "mcycleh_carry");
    csr_req(1, 0, 0, 12'hB00, 1, cyc_model[31:0], "mcycle_lo");
    csr_req(0, 1, 32'h0000_F0F0, 12'hB02, 1, 32'd0, "wr_minstret");
    csr_req(0, 2, 32'h0000_0F00, 12'hB02, 1, 32'h0000_F0F0, "set_minstret");
    csr_req(0, 3, 32'h0000_00F0, 12'hB02, 1, 32'h0000_FFF0, "clr_minstret");
    csr_req(1, 0, 0, 12'hB02, 1, 32'h0000_FF00, "minstret");
    retired = 1'b1;
    repeat (5) tick();
    retired = 1'b0;
    csr_req(1, 0, 0, 12'hC02, 1, 32'h0000_FF05, "instret_p5");
    csr_req(1, 0, 0, 12'hC82, 1, 32'd0, "instreth");
    csr_req(0, 1, 32'h1234, 12'hC00, 1, cyc_model[31:0], "wr_cycle_ro");
    csr_req(1, 0, 0, 12'hC01, 1, cyc_model[31:0], "time_alias");
    csr_req(1, 0, 0, 12'hC80, 1, cyc_model[63:32], "cycleh");

    // UART transmit 0x55
    csr_req(0, 1, 32'h55, 12'hBC0, 1, 32'h0, "wr_uart");
    check("tx_start0", {31'd0, tx}, 32'd0);
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h200, "uart_busy");
    csr_req(0, 1, 32'hAA, 12'hBC0, 1, 32'h200, "uart_wr_busy");
    repeat (DIV - 3) tick();
    check("tx_start_end", {31'd0, tx}, 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    tick();
    check("tx_bit0", {31'd0, tx}, {31'd0, frame[1]});
    for (int j = 2; j < 10; j++) begin
      repeat (DIV) tick();
      check($sformatf("tx_frame%0d", j), {31'd0, tx}, {31'd0, frame[j]});
    end
    repeat (DIV) tick();
    check("tx_idle", {31'd0, tx}, 32'd1);
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h0, "uart_done");

    // UART receive, pop, glitch, bad stop, overrun
    send_byte(8'hA3, 1'b1);
    repeat (20) tick();
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h1A3, "rx_a3");
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h0A3, "rx_popped");
    rx = 1'b0;
    repeat (20) tick();
    rx = 1'b1;
    repeat (2 * DIV) tick();
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h0A3, "rx_glitch");
    send_byte(8'h3C, 1'b0);
    repeat (2 * DIV) tick();
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h0A3, "rx_badstop");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (20) tick();
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h122, "rx_overrun");

    // unmapped / no request
    csr_req(1, 0, 0, 12'h300, 0, 32'h0, "unmapped");
    csr_req(0, 0, 32'hFF, 12'hBC0, 0, 32'h0, "no_req");
    csr_req(0, 5, 32'hFF, 12'hFC0, 0, 32'h0, "modify5");

    // reset in the middle of a transmission
    csr_req(0, 1, 32'h0F, 12'hBC0, 1, 32'h022, "wr_uart2");
    repeat (300) tick();
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h222, "uart2_busy");
    rst = 1'b1;
    tick();
    check("midrst_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    csr_req(1, 0, 0, 12'hBC0, 1, 32'h0, "midrst_uart");
    csr_req(1, 0, 0, 12'hC00, 1, cyc_model[31:0], "midrst_cycle");
    csr_req(1, 0, 0, 12'hC02, 1, 32'd0, "midrst_instret");
    check("midrst_tx_idle", {31'd0, tx}, 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
